tap_ctrl: RTL and testbench

//   IEEE 1149.1 TAP controller that sequences the boundary-scan register chain (bsr).

---
 rtl/tap_ctrl_pkg.sv | 48 ++++
 rtl/tap_ctrl_if.sv | 21 ++
 rtl/tap_ctrl_fsm.sv | 58 +++++
 rtl/tap_ctrl.sv | 101 ++++++++++
 tb/tb_tap_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/tap_ctrl_pkg.sv
// Shared types and default constants for the JTAG TAP controller.
package tap_ctrl_pkg;

  // The 16 IEEE 1149.1 TAP controller states, 4-bit encoded.
  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PAU_DR = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PAU_IR = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_e;

  // Data register currently routed between TDI and TDO.
  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_BSR    = 2'd1,
    SEL_ID     = 2'd2
  } dr_sel_e;

  // One-hot style state-decode strobes from the FSM.
  typedef struct packed {
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic tlr;
  } tap_strobes_t;

  // Default device ID and opcodes (4-bit form; resized to IR_W at the top).
  localparam logic [31:0] IDCODE_DEF    = 32'h1000_0001;
  localparam logic [3:0]  OP_EXTEST_DEF = 4'b0000;
  localparam logic [3:0]  OP_SAMPLE_DEF = 4'b0001;
  localparam logic [3:0]  OP_IDCODE_DEF = 4'b0010;

endpackage

// File: rtl/tap_ctrl_if.sv
// Control/data bundle between the TAP controller and the boundary-scan chain.
interface tap_ctrl_if;
  logic bsr_s_in;
  logic bsr_s_out;
  logic bsr_mode;
  logic bsr_shift_dr;
  logic bsr_clk_dr;
  logic bsr_update_dr;

  // TAP controller side.
  modport master (
    output bsr_s_in, bsr_mode, bsr_shift_dr, bsr_clk_dr, bsr_update_dr,
    input  bsr_s_out
  );

  // Boundary-scan chain side.
  modport slave (
    input  bsr_s_in, bsr_mode, bsr_shift_dr, bsr_clk_dr, bsr_update_dr,
    output bsr_s_out
  );
endinterface

// File: rtl/tap_ctrl_fsm.sv
// 16-state IEEE 1149.1 TAP state machine; emits state-decode strobes only.
module tap_ctrl_fsm
  import tap_ctrl_pkg::*;
(
  input  logic         ICLK,
  input  logic         RSTn,
  input  logic         TMS,
  output tap_strobes_t strb
);

  tap_state_e state;
  tap_state_e state_next;

  // State register: TRST forces Test-Logic-Reset asynchronously.
  always_ff @(posedge ICLK or negedge RSTn) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!RSTn) state <= TLR;
    else       state <= state_next;
  end

  // Next-state decode from TMS following the 1149.1 state diagram.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      TLR:    state_next = TMS ? TLR    : RTI;
      RTI:    state_next = TMS ? SEL_DR : RTI;
      SEL_DR: state_next = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_next = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_next = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_next = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_next = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_next = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_next = TMS ? SEL_DR : RTI;
      SEL_IR: state_next = TMS ? TLR    : CAP_IR;
      CAP_IR: state_next = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_next = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_next = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_next = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_next = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_next = TMS ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // Output decode: one strobe per state the datapath acts on.
  always_comb begin
    strb            = '0;
    strb.capture_dr = (state == CAP_DR);
    strb.shift_dr   = (state == SH_DR);
    strb.update_dr  = (state == UPD_DR);
    strb.capture_ir = (state == CAP_IR);
    strb.shift_ir   = (state == SH_IR);
    strb.update_ir  = (state == UPD_IR);
    strb.tlr        = (state == TLR);
  end

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP controller: instruction register, BYPASS/IDCODE registers, DR
// select, registered TDO mux and boundary-scan chain control decode.
module tap_ctrl
  import tap_ctrl_pkg::*;
#(
  parameter int              IR_W      = 4,
  parameter logic [31:0]     IDCODE    = IDCODE_DEF,
  parameter logic [IR_W-1:0] OP_EXTEST = IR_W'(OP_EXTEST_DEF),
  parameter logic [IR_W-1:0] OP_SAMPLE = IR_W'(OP_SAMPLE_DEF),
  parameter logic [IR_W-1:0] OP_IDCODE = IR_W'(OP_IDCODE_DEF)
) (
  input  logic              ICLK,
  input  logic              RSTn,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              TDO_oe,
  tap_ctrl_if.master        bsr,
  output logic [IR_W-1:0]   ir_out
);

  tap_strobes_t    strb;
  logic [IR_W-1:0] ir_sr;
  logic [31:0]     id_reg;
  logic            bypass;
  logic            tdo_next;
  dr_sel_e         dr_sel;

  tap_ctrl_fsm u_fsm (
    .ICLK (ICLK),
    .RSTn (RSTn),
    .TMS  (TMS),
    .strb (strb)
  );

  // Instruction decode to the data register placed between TDI and TDO.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_out == OP_EXTEST || ir_out == OP_SAMPLE) dr_sel = SEL_BSR;
    else if (ir_out == OP_IDCODE)                   dr_sel = SEL_ID;
  end

  // Instruction shift register and active instruction; TLR restores IDCODE.
  always_ff @(posedge ICLK or negedge RSTn) begin
    if (!RSTn) begin
      ir_sr  <= '0;
      ir_out <= OP_IDCODE;
    end else if (strb.tlr) begin
      ir_sr  <= '0;
      ir_out <= OP_IDCODE;
    end else begin
      if (strb.capture_ir)    ir_sr <= IR_W'(2'b01);
      else if (strb.shift_ir) ir_sr <= {TDI, ir_sr[IR_W-1:1]};
      if (strb.update_ir)     ir_out <= ir_sr;
    end
  end

  // BYPASS and IDCODE data registers: parallel capture, then shift right.
  always_ff @(posedge ICLK or negedge RSTn) begin
    if (!RSTn) begin
      bypass <= 1'b0;
      id_reg <= IDCODE;
    end else if (strb.tlr) begin
      bypass <= 1'b0;
    end else if (strb.capture_dr) begin
      bypass <= 1'b0;
      id_reg <= IDCODE;
    end else if (strb.shift_dr) begin
      if (dr_sel == SEL_BYPASS) bypass <= TDI;
      if (dr_sel == SEL_ID)     id_reg <= {TDI, id_reg[31:1]};
    end
  end

  // TDO source: LSB of the register being shifted, zero otherwise.
  always_comb begin
    tdo_next = 1'b0;
    if (strb.shift_dr) begin
      case (dr_sel)
        SEL_BSR: tdo_next = bsr.bsr_s_out;
        SEL_ID:  tdo_next = id_reg[0];
        default: tdo_next = bypass;
      endcase
    end else if (strb.shift_ir) begin
      tdo_next = ir_sr[0];
    end
  end

  // Registered TDO so shifted data appears one ICLK after the shift edge.
  always_ff @(posedge ICLK or negedge RSTn) begin
    if (!RSTn) TDO <= 1'b0;
    else       TDO <= tdo_next;
  end

  assign TDO_oe            = strb.shift_dr | strb.shift_ir;
  assign bsr.bsr_s_in      = TDI;
  assign bsr.bsr_mode      = (ir_out == OP_EXTEST);
  assign bsr.bsr_shift_dr  = strb.shift_dr;
  assign bsr.bsr_clk_dr    = (strb.capture_dr | strb.shift_dr) & (dr_sel == SEL_BSR);
  assign bsr.bsr_update_dr = strb.update_dr & (dr_sel == SEL_BSR);

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed testbench for tap_ctrl with an 8-bit boundary-scan chain model.
module tb_tap_ctrl;
  import tap_ctrl_pkg::*;

  localparam logic [7:0] BSR_CAPT = 8'h3C;

  logic       ICLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       TMS  = 1'b1;
  logic       TDI  = 1'b0;
  logic       TDO;
  logic       TDO_oe;
  logic [3:0] ir_out;

  int   checks   = 0;
  int   failures = 0;
  int   clk_cnt  = 0;
  int   upd_cnt  = 0;
  logic pre_upd_mode = 1'b0;

  logic [63:0] dout;
  logic [3:0]  ir_dout;

  tap_ctrl_if bsr_bus ();

  tap_ctrl #(.IR_W(4)) dut (
    .ICLK   (ICLK),
    .RSTn   (RSTn),
    .TMS    (TMS),
    .TDI    (TDI),
    .TDO    (TDO),
    .TDO_oe (TDO_oe),
    .bsr    (bsr_bus.master),
    .ir_out (ir_out)
  );

  always #5 ICLK = ~ICLK;

  // Boundary-scan chain model: capture BSR_CAPT, shift right with s_in at MSB.
  logic [7:0] bsr_model = 8'h00;
  assign bsr_bus.bsr_s_out = bsr_model[0];
  always @(posedge ICLK) begin
    if (bsr_bus.bsr_clk_dr)
      bsr_model <= bsr_bus.bsr_shift_dr ? {bsr_bus.bsr_s_in, bsr_model[7:1]} : BSR_CAPT;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply TMS/TDI for one ICLK; count strobes active for that edge.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    #1;
    if (bsr_bus.bsr_clk_dr)    clk_cnt++;
    if (bsr_bus.bsr_update_dr) upd_cnt++;
    @(posedge ICLK);
    #1;
  endtask

  // Full DR scan from RTI back to RTI; dout[i] is TDO after shift edge i.
  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] d);
    d = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      d[i] = TDO;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Full IR scan from RTI back to RTI.
  task automatic scan_ir(input logic [3:0] ir, output logic [3:0] d);
    d = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, ir[i]);
      d[i] = TDO;
    end
    step(1'b1, 1'b0);
    pre_upd_mode = bsr_bus.bsr_mode;
    step(1'b0, 1'b0);
  endtask

  tap_state_e  walk_state [16] = '{RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
                                   SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR, TLR};
  int          walk_len   [16] = '{0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5, 3};
  logic [7:0]  walk_tms   [16] = '{8'b0, 8'b1, 8'b01, 8'b001, 8'b101, 8'b0101, 8'b10101,
                                   8'b1101, 8'b11, 8'b011, 8'b0011, 8'b1011, 8'b01011,
                                   8'b101011, 8'b11011, 8'b111};

  initial begin
    // Reset state
    #12;
    check("rst_ir_out", 64'(ir_out), 64'h2);
    check("rst_tdo", 64'(TDO), 64'h0);
    check("rst_tdo_oe", 64'(TDO_oe), 64'h0);
    check("rst_bsr_ctrl", 64'({bsr_bus.bsr_mode, bsr_bus.bsr_shift_dr,
                               bsr_bus.bsr_clk_dr, bsr_bus.bsr_update_dr}), 64'h0);
    RSTn = 1'b1;
    @(posedge ICLK);
    #1;
    check("rst_state", 64'(dut.u_fsm.state), 64'(TLR));

    // IDCODE scan straight after reset
    step(1'b0, 1'b0);
    clk_cnt = 0;
    scan_dr(32, 64'h0, dout);
    check("idcode_stream", dout, 64'h1000_0001);
    check("idcode_no_bsr_clk", 64'(clk_cnt), 64'h0);

    // BYPASS: IR capture pattern, then A5 delayed by one bit
    scan_ir(4'b1111, ir_dout);
    check("ir_capture_tdo", 64'(ir_dout), 64'h1);
    check("bypass_ir_out", 64'(ir_out), 64'hF);
    scan_dr(9, 64'h0A5, dout);
    check("bypass_stream", dout, 64'h14A);

    // EXTEST: mode after UPD_IR, 33 clk_dr cycles and one update strobe
    scan_ir(4'b0000, ir_dout);
    check("extest_mode_before_upd", 64'(pre_upd_mode), 64'h0);
    check("extest_mode", 64'(bsr_bus.bsr_mode), 64'h1);
    check("extest_ir_out", 64'(ir_out), 64'h0);
    clk_cnt = 0;
    upd_cnt = 0;
    scan_dr(32, 64'hDEAD_BEEF, dout);
    check("extest_clk_dr_cycles", 64'(clk_cnt), 64'd33);
    check("extest_update_pulses", 64'(upd_cnt), 64'd1);

    // Reset pulse in the middle of SH_DR under EXTEST
    upd_cnt = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("midshift_pre_oe", 64'(TDO_oe), 64'h1);
    check("midshift_pre_ctrl", 64'({bsr_bus.bsr_mode, bsr_bus.bsr_shift_dr,
                                    bsr_bus.bsr_clk_dr}), 64'h7);
    RSTn = 1'b0;
    #2;
    check("midshift_state", 64'(dut.u_fsm.state), 64'(TLR));
    check("midshift_ir_out", 64'(ir_out), 64'h2);
    check("midshift_tdo", 64'(TDO), 64'h0);
    check("midshift_tdo_oe", 64'(TDO_oe), 64'h0);
    check("midshift_bsr_ctrl", 64'({bsr_bus.bsr_mode, bsr_bus.bsr_shift_dr,
                                    bsr_bus.bsr_clk_dr, bsr_bus.bsr_update_dr}), 64'h0);
    check("midshift_no_update", 64'(upd_cnt), 64'h0);
    #2;
    RSTn = 1'b1;
    @(posedge ICLK);
    #1;

    // SAMPLE with a 3-cycle PAU_DR in the middle of an 8-bit scan
    step(1'b0, 1'b0);
    scan_ir(4'b0001, ir_dout);
    check("sample_ir_out", 64'(ir_out), 64'h1);
    check("sample_mode", 64'(bsr_bus.bsr_mode), 64'h0);
    upd_cnt = 0;
    dout = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, dout[63] ^ 1'b0 ? 1'b0 : 8'hC6 >> i & 8'h1 ? 1'b1 : 1'b0);
      dout[i] = TDO;
    end
    step(1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      check("pause_ctrl", 64'({bsr_bus.bsr_shift_dr, bsr_bus.bsr_clk_dr, TDO_oe}), 64'h0);
      check("pause_data", 64'(bsr_model), 64'h63);
      step(p == 2, 1'b0);
    end
    step(1'b0, 1'b0);
    for (int i = 4; i < 8; i++) begin
      step(i == 7, 8'hC6 >> i & 8'h1 ? 1'b1 : 1'b0);
      dout[i] = TDO;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("sample_tdo_stream", dout, 64'h3C);
    check("sample_chain_data", 64'(bsr_model), 64'hC6);
    check("sample_update_pulses", 64'(upd_cnt), 64'd1);

    // Five TMS=1 clocks from every state reach TLR
    RSTn = 1'b0;
    #2;
    RSTn = 1'b1;
    @(posedge ICLK);
    #1;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0);
      for (int j = 0; j < walk_len[k]; j++) step(walk_tms[k][j], 1'b0);
      check("walk_reach", 64'(dut.u_fsm.state), 64'(walk_state[k]));
      for (int j = 0; j < 5; j++) step(1'b1, 1'b0);
      check("walk_tlr", 64'(dut.u_fsm.state), 64'(TLR));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
